// File: rtl/caxi4interconnect_ram_fifo_ctrl_pkg.sv
// ----------------------------------------------------------------------------
// caxi4interconnect_ram_fifo_ctrl_pkg
// Shared constants and helpers for the RAM-backed FIFO controller:
//   calcLat   - RAM read latency in cycles (1, or 2 with the output register)
//   bufDepth  - output skid buffer depth (LAT+1 entries)
//   cntWidth  - width of a 0..2**awidth occupancy counter
//   BUF_CNT_W - width of buffer / in-flight counters (max depth is 3)
//   SUM_W     - width of bufCount+inFlight without overflow
// ----------------------------------------------------------------------------
package caxi4interconnect_ram_fifo_ctrl_pkg;

   localparam int unsigned BUF_CNT_W = 2;
   localparam int unsigned SUM_W     = BUF_CNT_W + 1;

   function automatic int unsigned calcLat(input int unsigned hiFreq);
      return (hiFreq != 0) ? 2 : 1;
   endfunction

   function automatic int unsigned bufDepth(input int unsigned hiFreq);
      return calcLat(hiFreq) + 1;
   endfunction

   function automatic int unsigned cntWidth(input int unsigned awidth);
      return awidth + 1;
   endfunction

endpackage

// File: rtl/caxi4interconnect_ram_fifo_ctrl_if.sv
// ----------------------------------------------------------------------------
// caxi4interconnect_ram_fifo_ctrl_if
// Push/pop handshake bundle for the RAM FIFO controller.
//   wrValid/wrReady/wrData : push side
//   rdValid/rdReady/rdData : pop side
//   fifoLevel              : RAM occupancy, only with CAXI4INTERCONNECT_FIFO_LEVEL_EN
// Modports: slave = FIFO side, master = user side.
// Optional feature macro: CAXI4INTERCONNECT_FIFO_LEVEL_EN
// ----------------------------------------------------------------------------
interface caxi4interconnect_ram_fifo_ctrl_if #(
   parameter int unsigned FIFO_WIDTH  = 8
`ifdef CAXI4INTERCONNECT_FIFO_LEVEL_EN
   ,
   parameter int unsigned FIFO_AWIDTH = 9
`endif
);

   logic                  wrValid;
   logic                  wrReady;
   logic [FIFO_WIDTH-1:0] wrData;
   logic                  rdValid;
   logic                  rdReady;
   logic [FIFO_WIDTH-1:0] rdData;

`ifdef CAXI4INTERCONNECT_FIFO_LEVEL_EN
   logic [FIFO_AWIDTH:0]  fifoLevel;

   modport slave  (input  wrValid, wrData, rdReady,
                   output wrReady, rdValid, rdData, fifoLevel);
   modport master (output wrValid, wrData, rdReady,
                   input  wrReady, rdValid, rdData, fifoLevel);
`else
   modport slave  (input  wrValid, wrData, rdReady,
                   output wrReady, rdValid, rdData);
   modport master (output wrValid, wrData, rdReady,
                   input  wrReady, rdValid, rdData);
`endif

endinterface

// File: rtl/caxi4interconnect_DualPort_RAM_SyncWr_SyncRd.sv
// ----------------------------------------------------------------------------
// caxi4interconnect_DualPort_RAM_SyncWr_SyncRd
// Simple dual-port RAM, synchronous write and synchronous read.
// With HI_FREQ != 0 an extra output register is added (read latency 2).
// Ports:
//   HCLK          clock
//   wrEn/wrAddr/wrData   write port
//   rdEn/rdAddr   read request; rdData valid LAT cycles later
// Contents are never reset.
// ----------------------------------------------------------------------------
module caxi4interconnect_DualPort_RAM_SyncWr_SyncRd
   import caxi4interconnect_ram_fifo_ctrl_pkg::*;
#(
   parameter int unsigned FIFO_AWIDTH = 9,
   parameter int unsigned FIFO_WIDTH  = 8,
   parameter int unsigned HI_FREQ     = 0
) (
   input  logic                   HCLK,
   input  logic                   wrEn,
   input  logic [FIFO_AWIDTH-1:0] wrAddr,
   input  logic [FIFO_WIDTH-1:0]  wrData,
   input  logic                   rdEn,
   input  logic [FIFO_AWIDTH-1:0] rdAddr,
   output logic [FIFO_WIDTH-1:0]  rdData
);

   logic [FIFO_WIDTH-1:0] mem [0:(1 << FIFO_AWIDTH)-1];
   logic [FIFO_WIDTH-1:0] rdRaw;

   always_ff @(posedge HCLK) begin
      if (wrEn) mem[wrAddr] <= wrData;
      if (rdEn) rdRaw <= mem[rdAddr];
   end

   if (calcLat(HI_FREQ) > 1) begin : gOutReg
      logic [FIFO_WIDTH-1:0] rdReg;
      always_ff @(posedge HCLK) rdReg <= rdRaw;
      assign rdData = rdReg;
   end else begin : gNoOutReg
      assign rdData = rdRaw;
   end

endmodule

// File: rtl/caxi4interconnect_ram_fifo_ctrl.sv
// ----------------------------------------------------------------------------
// caxi4interconnect_ram_fifo_ctrl
// FIFO controller around a synchronous-read RAM. Words are fetched from RAM
// ahead of demand into a small (LAT+1)-entry skid buffer, so rdData is always
// a register and the pop side sees a plain valid/ready stream.
// Ports:
//   HCLK    clock, rising edge
//   HRESET  asynchronous active-high reset
//   bus     push/pop handshake (caxi4interconnect_ram_fifo_ctrl_if.slave)
// Optional feature macro: CAXI4INTERCONNECT_FIFO_LEVEL_EN adds bus.fifoLevel,
// the registered RAM occupancy. The bus interface instance must use the same
// FIFO_WIDTH (and FIFO_AWIDTH, when enabled) as this module.
// ----------------------------------------------------------------------------
module caxi4interconnect_ram_fifo_ctrl
   import caxi4interconnect_ram_fifo_ctrl_pkg::*;
#(
   parameter int unsigned FIFO_AWIDTH = 9,
   parameter int unsigned FIFO_WIDTH  = 8,
   parameter int unsigned HI_FREQ     = 0
) (
   input logic                          HCLK,
   input logic                          HRESET,
   caxi4interconnect_ram_fifo_ctrl_if.slave bus
);

   localparam int unsigned LAT       = calcLat(HI_FREQ);
   localparam int unsigned BUF_DEPTH = bufDepth(HI_FREQ);
   localparam int unsigned CNT_W     = cntWidth(FIFO_AWIDTH);
   localparam logic [CNT_W-1:0] DEPTH_CNT = {1'b1, {FIFO_AWIDTH{1'b0}}};

   logic [FIFO_AWIDTH-1:0] wrPtrQ, rdPtrQ;
   logic [CNT_W-1:0]       ramCountQ, ramCountD;
   logic [LAT-1:0]         inFlightQ, inFlightD;
   logic [BUF_CNT_W-1:0]   bufCountQ, bufCountD, inFlightCnt, capIdx;
   logic [FIFO_WIDTH-1:0]  bufQ [BUF_DEPTH];
   logic [FIFO_WIDTH-1:0]  bufD [BUF_DEPTH];
   logic [FIFO_WIDTH-1:0]  ramRdData;
   logic                   push, fetch, capture, pop;

   // Full is judged on the word count alone; pointers may be equal when empty or full.
   assign bus.wrReady = (ramCountQ < DEPTH_CNT);
   assign bus.rdValid = (bufCountQ != '0);
   assign bus.rdData  = bufQ[0];

`ifdef CAXI4INTERCONNECT_FIFO_LEVEL_EN
   assign bus.fifoLevel = ramCountQ;
`endif

   assign push    = bus.wrValid & bus.wrReady;
   assign pop     = bus.rdReady & bus.rdValid;
   assign capture = inFlightQ[LAT-1];

   always_comb begin
      inFlightCnt = '0;
      for (int i = 0; i < LAT; i++) begin
         inFlightCnt = inFlightCnt + BUF_CNT_W'(inFlightQ[i]);
      end
   end

   // A fetch reserves a buffer slot at issue time, so every returning word
   // is guaranteed a free entry regardless of the rdReady pattern.
   assign fetch = (ramCountQ != '0) &&
                  ((SUM_W'(bufCountQ) + SUM_W'(inFlightCnt)) < SUM_W'(BUF_DEPTH));

   assign ramCountD = ramCountQ + CNT_W'(push) - CNT_W'(fetch);
   assign inFlightD = (inFlightQ << 1) | LAT'(fetch);
   assign bufCountD = bufCountQ + BUF_CNT_W'(capture) - BUF_CNT_W'(pop);
   assign capIdx    = bufCountQ - BUF_CNT_W'(pop);

   // Shift-down skid buffer: entry 0 is always the head, so rdData needs no mux.
   always_comb begin
      bufD = bufQ;
      if (pop) begin
         for (int i = 0; i < BUF_DEPTH - 1; i++) bufD[i] = bufQ[i+1];
      end
      if (capture) begin
         for (int i = 0; i < BUF_DEPTH; i++) begin
            if (BUF_CNT_W'(i) == capIdx) bufD[i] = ramRdData;
         end
      end
   end

   always_ff @(posedge HCLK or posedge HRESET) begin
      if (HRESET) begin
         wrPtrQ    <= '0;
         rdPtrQ    <= '0;
         ramCountQ <= '0;
         inFlightQ <= '0;
         bufCountQ <= '0;
         bufQ      <= '{default: '0};
      end else begin
         wrPtrQ    <= wrPtrQ + FIFO_AWIDTH'(push);
         rdPtrQ    <= rdPtrQ + FIFO_AWIDTH'(fetch);
         ramCountQ <= ramCountD;
         inFlightQ <= inFlightD;
         bufCountQ <= bufCountD;
         bufQ      <= bufD;
      end
   end

   caxi4interconnect_DualPort_RAM_SyncWr_SyncRd #(
      .FIFO_AWIDTH (FIFO_AWIDTH),
      .FIFO_WIDTH  (FIFO_WIDTH),
      .HI_FREQ     (HI_FREQ)
   ) uRam (
      .HCLK   (HCLK),
      .wrEn   (push),
      .wrAddr (wrPtrQ),
      .wrData (bus.wrData),
      .rdEn   (fetch),
      .rdAddr (rdPtrQ),
      .rdData (ramRdData)
   );

endmodule

// File: tb/tb_caxi4interconnect_ram_fifo_ctrl.sv
// ----------------------------------------------------------------------------
// tb_caxi4interconnect_ram_fifo_ctrl
// dut0: FIFO_AWIDTH=2, HI_FREQ=0 (cycle-exact vector table, level, reset,
//       random scoreboard). dut1: FIFO_AWIDTH=2, HI_FREQ=1 (latency, capacity).
// Level checks are active when CAXI4INTERCONNECT_FIFO_LEVEL_EN is defined.
// ----------------------------------------------------------------------------
module tb_caxi4interconnect_ram_fifo_ctrl;

   logic HCLK   = 1'b0;
   logic HRESET = 1'b1;
   int   errors = 0;
   int   checks = 0;

   always #5 HCLK = ~HCLK;

`ifdef CAXI4INTERCONNECT_FIFO_LEVEL_EN
   caxi4interconnect_ram_fifo_ctrl_if #(.FIFO_WIDTH(8), .FIFO_AWIDTH(2)) bus0 ();
   caxi4interconnect_ram_fifo_ctrl_if #(.FIFO_WIDTH(8), .FIFO_AWIDTH(2)) bus1 ();
`else
   caxi4interconnect_ram_fifo_ctrl_if #(.FIFO_WIDTH(8)) bus0 ();
   caxi4interconnect_ram_fifo_ctrl_if #(.FIFO_WIDTH(8)) bus1 ();
`endif

   caxi4interconnect_ram_fifo_ctrl #(
      .FIFO_AWIDTH (2),
      .FIFO_WIDTH  (8),
      .HI_FREQ     (0)
   ) dut0 (
      .HCLK   (HCLK),
      .HRESET (HRESET),
      .bus    (bus0)
   );

   caxi4interconnect_ram_fifo_ctrl #(
      .FIFO_AWIDTH (2),
      .FIFO_WIDTH  (8),
      .HI_FREQ     (1)
   ) dut1 (
      .HCLK   (HCLK),
      .HRESET (HRESET),
      .bus    (bus1)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   typedef struct {
      logic       wv;
      logic [7:0] wd;
      logic       rr;
      logic       expWr;
      logic       expRv;
      logic [7:0] expRd;
      logic [2:0] expLvl;
   } vec_t;

   vec_t vecs [30];

   logic [7:0] q [$];

   initial begin
      int got, sent, acc;

      // {wrValid, wrData, rdReady, expWrReady, expRdValid, expRdData, expLevel}
      vecs[0]  = '{1'b1, 8'hA5, 1'b1, 1'b1, 1'b0, 8'h00, 3'd0};
      vecs[1]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00, 3'd1};
      vecs[2]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00, 3'd0};
      vecs[3]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'hA5, 3'd0};
      vecs[4]  = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00, 3'd0};
      vecs[5]  = '{1'b1, 8'h01, 1'b0, 1'b1, 1'b0, 8'h00, 3'd0};
      vecs[6]  = '{1'b1, 8'h02, 1'b0, 1'b1, 1'b0, 8'h00, 3'd1};
      vecs[7]  = '{1'b1, 8'h03, 1'b0, 1'b1, 1'b0, 8'h00, 3'd1};
      vecs[8]  = '{1'b1, 8'h04, 1'b0, 1'b1, 1'b1, 8'h01, 3'd1};
      vecs[9]  = '{1'b1, 8'h05, 1'b0, 1'b1, 1'b1, 8'h01, 3'd2};
      vecs[10] = '{1'b1, 8'h06, 1'b0, 1'b1, 1'b1, 8'h01, 3'd3};
      vecs[11] = '{1'b1, 8'h07, 1'b0, 1'b0, 1'b1, 8'h01, 3'd4};
      vecs[12] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h01, 3'd4};
      vecs[13] = '{1'b0, 8'h00, 1'b1, 1'b0, 1'b1, 8'h02, 3'd4};
      vecs[14] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00, 3'd3};
      vecs[15] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h03, 3'd2};
      vecs[16] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h04, 3'd2};
      vecs[17] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00, 3'd1};
      vecs[18] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h05, 3'd0};
      vecs[19] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h06, 3'd0};
      vecs[20] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00, 3'd0};
      vecs[21] = '{1'b1, 8'h10, 1'b1, 1'b1, 1'b0, 8'h00, 3'd0};
      vecs[22] = '{1'b1, 8'h11, 1'b1, 1'b1, 1'b0, 8'h00, 3'd1};
      vecs[23] = '{1'b1, 8'h12, 1'b1, 1'b1, 1'b0, 8'h00, 3'd1};
      vecs[24] = '{1'b1, 8'h13, 1'b1, 1'b1, 1'b1, 8'h10, 3'd1};
      vecs[25] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h11, 3'd2};
      vecs[26] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00, 3'd1};
      vecs[27] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h12, 3'd0};
      vecs[28] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b1, 8'h13, 3'd0};
      vecs[29] = '{1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h00, 3'd0};

      bus0.wrValid = 1'b0; bus0.wrData = '0; bus0.rdReady = 1'b0;
      bus1.wrValid = 1'b0; bus1.wrData = '0; bus1.rdReady = 1'b0;

      // Reset state
      repeat (2) @(negedge HCLK);
      check("rst0_wrReady", bus0.wrReady, 1);
      check("rst0_rdValid", bus0.rdValid, 0);
      check("rst0_rdData",  bus0.rdData,  0);
      check("rst1_wrReady", bus1.wrReady, 1);
      check("rst1_rdValid", bus1.rdValid, 0);
`ifdef CAXI4INTERCONNECT_FIFO_LEVEL_EN
      check("rst0_level", bus0.fifoLevel, 0);
`endif
      HRESET = 1'b0;

      // Cycle-exact vector table on dut0
      for (int r = 0; r < 30; r++) begin
         @(negedge HCLK);
         bus0.wrValid = vecs[r].wv;
         bus0.wrData  = vecs[r].wd;
         bus0.rdReady = vecs[r].rr;
         check($sformatf("vec%0d_wrReady", r), bus0.wrReady, vecs[r].expWr);
         check($sformatf("vec%0d_rdValid", r), bus0.rdValid, vecs[r].expRv);
         if (vecs[r].expRv) check($sformatf("vec%0d_rdData", r), bus0.rdData, vecs[r].expRd);
`ifdef CAXI4INTERCONNECT_FIFO_LEVEL_EN
         check($sformatf("vec%0d_level", r), bus0.fifoLevel, vecs[r].expLvl);
`endif
      end
      @(negedge HCLK);
      bus0.wrValid = 1'b0;
      bus0.rdReady = 1'b0;

      // Five pushes with no pops: two words prefetched, three left in RAM
      for (int i = 0; i < 5; i++) begin
         bus0.wrValid = 1'b1;
         bus0.wrData  = 8'(8'h21 + i);
         @(negedge HCLK);
      end
      bus0.wrValid = 1'b0;
      repeat (4) @(negedge HCLK);
      check("lvl_rdValid", bus0.rdValid, 1);
      check("lvl_head",    bus0.rdData,  8'h21);
      check("lvl_wrReady", bus0.wrReady, 1);
`ifdef CAXI4INTERCONNECT_FIFO_LEVEL_EN
      check("lvl_level", bus0.fifoLevel, 3);
`endif
      bus0.rdReady = 1'b1;
      got = 0;
      for (int c = 0; c < 30 && got < 5; c++) begin
         if (bus0.rdValid) begin
            check("lvl_drain_data", bus0.rdData, 32'(8'h21 + got));
            got++;
         end
         @(negedge HCLK);
      end
      check("lvl_drain_count", got, 5);
      check("lvl_drain_empty", bus0.rdValid, 0);
      bus0.rdReady = 1'b0;

      // Asynchronous reset in the middle of a burst
      for (int i = 0; i < 4; i++) begin
         bus0.wrValid = 1'b1;
         bus0.wrData  = 8'(8'h11 + i);
         @(negedge HCLK);
      end
      bus0.wrValid = 1'b0;
      check("prerst_rdValid", bus0.rdValid, 1);
      @(posedge HCLK);
      #2 HRESET = 1'b1;
      #1;
      check("arst_rdValid", bus0.rdValid, 0);
      check("arst_wrReady", bus0.wrReady, 1);
      check("arst_rdData",  bus0.rdData,  0);
`ifdef CAXI4INTERCONNECT_FIFO_LEVEL_EN
      check("arst_level", bus0.fifoLevel, 0);
`endif
      @(negedge HCLK);
      HRESET = 1'b0;
      bus0.wrValid = 1'b1;
      bus0.wrData  = 8'h77;
      bus0.rdReady = 1'b1;
      @(negedge HCLK);
      bus0.wrValid = 1'b0;
      got = 0;
      for (int c = 0; c < 12; c++) begin
         if (bus0.rdValid) begin
            if (got == 0) check("arst_first_word", bus0.rdData, 8'h77);
            got++;
         end
         @(negedge HCLK);
      end
      check("arst_word_count", got, 1);

      // Random valid/ready scoreboard on dut0
      q.delete();
      sent = 0;
      got  = 0;
      for (int c = 0; c < 40000 && got < 4000; c++) begin
         bus0.wrValid = (sent < 4000) && ($urandom_range(0, 1) == 1);
         bus0.wrData  = 8'($urandom_range(0, 255));
         bus0.rdReady = ($urandom_range(0, 1) == 1);
         if (bus0.wrValid && bus0.wrReady) begin
            q.push_back(bus0.wrData);
            sent++;
         end
         if (bus0.rdValid && bus0.rdReady) begin
            check("rnd_data", bus0.rdData, (q.size() != 0) ? 32'(q.pop_front()) : 32'hDEAD);
            got++;
         end
         @(negedge HCLK);
      end
      check("rnd_words", got, 4000);
      bus0.wrValid = 1'b0;
      bus0.rdReady = 1'b0;

      // dut1 (HI_FREQ=1): first word visible after edge 3
      @(negedge HCLK);
      bus1.wrValid = 1'b1;
      bus1.wrData  = 8'h5A;
      bus1.rdReady = 1'b1;
      @(negedge HCLK);
      bus1.wrValid = 1'b0;
      for (int k = 0; k < 3; k++) begin
         check($sformatf("hf_lat_edge%0d", k), bus1.rdValid, 0);
         @(negedge HCLK);
      end
      check("hf_lat_rdValid", bus1.rdValid, 1);
      check("hf_lat_rdData",  bus1.rdData,  8'h5A);
      @(negedge HCLK);
      check("hf_lat_single", bus1.rdValid, 0);

      // dut1 capacity: 4 RAM words plus 3 prefetched
      bus1.rdReady = 1'b0;
      acc = 0;
      for (int c = 0; c < 20; c++) begin
         bus1.wrValid = 1'b1;
         bus1.wrData  = 8'(acc);
         if (bus1.wrReady) acc++;
         @(negedge HCLK);
      end
      bus1.wrValid = 1'b0;
      check("hf_full_wrReady", bus1.wrReady, 0);
      check("hf_capacity", acc, 7);
      bus1.rdReady = 1'b1;
      got = 0;
      for (int c = 0; c < 40 && got < 7; c++) begin
         if (bus1.rdValid) begin
            check("hf_drain_data", bus1.rdData, 32'(got));
            got++;
         end
         @(negedge HCLK);
      end
      check("hf_drain_count", got, 7);
      check("hf_drain_wrReady", bus1.wrReady, 1);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/caxi4interconnect_ram_fifo_ctrl.md
CAXI4INTERCONNECT_RAM_FIFO_CTRL -- requirements
Module: caxi4interconnect_ram_fifo_ctrl

Interface
REQ-001 SHALL have parameter FIFO_AWIDTH, default 9: RAM address width; FIFO_DEPTH = 2**FIFO_AWIDTH.
REQ-002 SHALL have parameter FIFO_WIDTH, default 8: data word width.
REQ-003 SHALL have parameter HI_FREQ, default 0: 1 adds a RAM output register; RAM latency LAT = 1+HI_FREQ.
REQ-004 SHALL have port HCLK  in  1  single clock; all logic on rising edge.
REQ-005 SHALL have port HRESET  in  1  reset, asynchronous, active-high.
REQ-006 SHALL have port wrValid  in  1  push request.
REQ-007 SHALL have port wrReady  out  1  push accepted when wrValid&wrReady.
REQ-008 SHALL have port wrData  in  FIFO_WIDTH  push data.
REQ-009 SHALL have port rdValid  out  1  rdData holds oldest word.
REQ-010 SHALL have port rdReady  in  1  pop when rdValid&rdReady.
REQ-011 SHALL have port rdData  out  FIFO_WIDTH  head-of-queue data, registered.
REQ-012 SHALL have port fifoLevel  out  FIFO_AWIDTH+1  RAM occupancy; present only under CAXI4INTERCONNECT_FIFO_LEVEL_EN.

Function
REQ-013 SHALL write wrData to RAM at wrPtr on every push edge; wrPtr increments modulo FIFO_DEPTH.
REQ-014 SHALL keep ramCount = words written but not yet fetched; wrReady = (ramCount < FIFO_DEPTH), driven from registers only (no rdReady->wrReady path).
REQ-015 SHALL issue a fetch (present rdPtr to RAM, rdPtr increments modulo FIFO_DEPTH) in any cycle where ramCount>0 and bufCount+inFlight < LAT+1.
REQ-016 SHALL track in-flight fetches in a LAT-stage valid shift register; returning data SHALL be captured into a (LAT+1)-entry output skid buffer.
REQ-017 SHALL present buffer head on rdData with rdValid = (bufCount>0); data SHALL emerge in push order, no loss or duplication.
REQ-018 Latency: word pushed into empty FIFO at edge 0 SHALL make rdValid high after edge 2+HI_FREQ.
REQ-019 A word pushed at edge N SHALL NOT be fetched before cycle N+1 (RAM write commits at edge N).
REQ-020 Simultaneous push and fetch SHALL update ramCount by net zero; simultaneous capture and pop SHALL hold bufCount.
REQ-021 Full (ramCount=FIFO_DEPTH) SHALL deassert wrReady; wrValid while full SHALL be ignored, no pointer change.
REQ-022 Pop when rdValid=0 SHALL be ignored; buffer never underflows or overflows under any rdReady pattern.
REQ-023 Pointer wrap SHALL be seamless; full vs empty resolved by ramCount, not pointer equality.

Reset
REQ-024 HRESET SHALL asynchronously clear wrPtr, rdPtr, ramCount, bufCount, in-flight valids; wrReady=1, rdValid=0, rdData=0, fifoLevel=0.
REQ-025 Reset mid-operation SHALL discard all queued and in-flight words; RAM contents are not reset; late RAM returns SHALL NOT be captured.

Configuration
REQ-026 With CAXI4INTERCONNECT_FIFO_LEVEL_EN defined, fifoLevel SHALL equal registered ramCount, updated the edge after each push/fetch.
REQ-027 Without CAXI4INTERCONNECT_FIFO_LEVEL_EN, port fifoLevel and its logic SHALL be absent; all other behaviour identical.

Structure
REQ-028 Shared package SHALL hold LAT computation, count/pointer width constants and buffer-depth constant.
REQ-029 Storage SHALL be one instance of sub-module caxi4interconnect_DualPort_RAM_SyncWr_SyncRd (HCLK, FIFO_AWIDTH, FIFO_WIDTH, HI_FREQ passed through); no other sub-modules.

Verification
REQ-030 HI_FREQ=0, single push 0xA5 at edge 0, rdReady=1 -> rdValid high after edge 2, rdData=0xA5, one cycle, then rdValid=0.
REQ-031 HI_FREQ=1, FIFO_AWIDTH=2, push 0..3 back-to-back, rdReady=0 -> wrReady=0 after 4 pushes plus prefetch refill; release rdReady -> 0,1,2,3 in order.
REQ-032 Random wrValid/rdReady (50%), 10000 words, FIFO_AWIDTH=3 -> scoreboard match, zero loss, pointers wrap >1000 times.
REQ-033 Push 0x11..0x14, assert HRESET asynchronously mid-burst -> rdValid=0, wrReady=1 immediately; next push 0x77 -> first output 0x77.
REQ-034 Macro defined, push 5 with rdReady=0, HI_FREQ=0 -> fifoLevel settles to 5-(LAT+1)=3; macro undefined -> build without fifoLevel port passes same bench.
